// File: rtl/noc_lfsr_traffic_gen_if.sv
// Local-port link from the traffic generator to the router: head packet plus valid/ready handshake.
interface noc_lfsr_traffic_gen_if #(
    parameter int DATA_W = 8,
    parameter int DEST_W = 4
);
    logic              out_valid;
    logic              out_ready;
    logic [DEST_W-1:0] out_dest;
    logic [DATA_W-1:0] out_data;

    modport master (output out_valid, output out_dest, output out_data, input out_ready);
    modport slave  (input out_valid, input out_dest, input out_data, output out_ready);
endinterface

// File: rtl/noc_lfsr_traffic_gen.sv
// LFSR-driven packet source for one mesh node: injection decision, FWFT output FIFO,
// saturating statistics counters and a bounded-run state machine.
module noc_lfsr_traffic_gen #(
    parameter int          DATA_W     = 8,
    parameter int          N_NODES    = 16,
    parameter int          NODE_ID    = 0,
    parameter logic [15:0] SEED       = 16'hACE1,
    parameter logic [15:0] TAPS       = 16'hB400,
    parameter int          RATE       = 256,
    parameter int          FIFO_DEPTH = 4,
    parameter int          MAX_PKTS   = 0
) (
    input  logic                          clk,
    input  logic                          reset,
    input  logic                          Write,
    noc_lfsr_traffic_gen_if.master        tx,
    output logic [15:0]                   gen_count,
    output logic [15:0]                   pkt_count,
    output logic [15:0]                   drop_count,
    output logic                          done
);
    localparam int DEST_W = $clog2(N_NODES);
    localparam int PTR_W  = $clog2(FIFO_DEPTH);
    localparam int ENT_W  = DEST_W + DATA_W;

    localparam logic [1:0] IDLE  = 2'd0;
    localparam logic [1:0] RUN   = 2'd1;
    localparam logic [1:0] DRAIN = 2'd2;
    localparam logic [1:0] DONE  = 2'd3;

    // RATE spans 0..256, so the threshold needs nine bits to express "always inject".
    localparam logic [8:0]        RATE_TH = 9'(RATE);
    localparam logic [DEST_W-1:0] SELF    = DEST_W'(NODE_ID);
    localparam logic [15:0]       MAX_CNT = 16'(MAX_PKTS);
    localparam logic [PTR_W:0]    FULL_CNT = (PTR_W+1)'(FIFO_DEPTH);

    function automatic logic [15:0] sat_inc(input logic [15:0] v);
        return (v == 16'hFFFF) ? v : v + 16'd1;
    endfunction

    logic [1:0]        state;
    logic [15:0]       lfsr;
    logic [15:0]       lfsr_next;
    logic [ENT_W-1:0]  mem [FIFO_DEPTH];
    logic [PTR_W-1:0]  wr_ptr;
    logic [PTR_W-1:0]  rd_ptr;
    logic [PTR_W:0]    count;
    logic [ENT_W-1:0]  head;
    logic [ENT_W-1:0]  last_head;
    logic [DEST_W-1:0] raw_dest;
    logic [DEST_W-1:0] dest;
    logic              gen_en;
    logic              inject;
    logic              empty;
    logic              full;
    logic              pop;
    logic              push;
    logic              drop;

    always_comb begin
        gen_en    = (state == RUN) && Write;
        inject    = gen_en && ({1'b0, lfsr[7:0]} < RATE_TH);
        raw_dest  = lfsr[8 +: DEST_W];
        dest      = (raw_dest == SELF) ? (SELF ^ DEST_W'(1)) : raw_dest;
        empty     = (count == '0);
        full      = (count == FULL_CNT);
        pop       = !empty && tx.out_ready;
        // A pop in the same cycle frees a slot, so a full FIFO still accepts the push.
        push      = inject && (!full || pop);
        drop      = inject && full && !pop;
        lfsr_next = (lfsr >> 1) ^ (lfsr[0] ? TAPS : 16'h0000);
        head      = mem[rd_ptr];
    end

    // Outputs show the head while non-empty, otherwise the last packet handed over.
    assign tx.out_valid = !empty;
    assign {tx.out_dest, tx.out_data} = empty ? last_head : head;
    assign done = (state == DONE);

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state      <= IDLE;
            lfsr       <= SEED;
            wr_ptr     <= '0;
            rd_ptr     <= '0;
            count      <= '0;
            last_head  <= '0;
            gen_count  <= '0;
            pkt_count  <= '0;
            drop_count <= '0;
        end else begin
            if (gen_en) lfsr <= lfsr_next;
            if (push) begin
                wr_ptr    <= wr_ptr + PTR_W'(1);
                gen_count <= sat_inc(gen_count);
            end
            if (pop) begin
                rd_ptr    <= rd_ptr + PTR_W'(1);
                last_head <= head;
                pkt_count <= sat_inc(pkt_count);
            end
            if (push && !pop)      count <= count + (PTR_W+1)'(1);
            else if (!push && pop) count <= count - (PTR_W+1)'(1);
            if (drop) drop_count <= sat_inc(drop_count);

            case (state)
                IDLE:  if (Write) state <= RUN;
                RUN: begin
                    if (!Write)
                        state <= IDLE;
                    else if ((MAX_PKTS != 0) && push && (sat_inc(gen_count) == MAX_CNT))
                        state <= DRAIN;
                end
                DRAIN: if (empty) state <= DONE;
                default: state <= DONE;
            endcase
        end
    end

    // Storage carries data only; occupancy is tracked by the reset pointers above.
    always_ff @(posedge clk) begin
        if (push) mem[wr_ptr] <= {dest, gen_count[DATA_W-1:0]};
    end
endmodule
